// File: rtl/mem_req_arbiter.sv
// ----------------------------------------------------------------------------
// mem_req_arbiter
//
// Shares one memory request channel between the I-cache (port I) and the
// D-cache (port D). Whole transactions are serialised: a grant latches the
// winner's request into the mem_req_* registers, the arbiter waits for the
// memory completion pulse, then returns a one-cycle registered ready pulse
// (with read data) to the owning port. Ties are resolved round-robin. A
// sticky timeout flag records any transaction that waited too long on memory.
//
// Parameters
//   ADDR_W        address width on all ports
//   DATA_W        data width on all ports
//   TIMEOUT       BUSY cycles without memory ready before timeout_err sets (>= 1)
//
// Ports
//   clk, rst      clock (rising edge), synchronous active-high reset
//   i_req_*       I-cache request: valid/addr/wr/wr_data in, ready/data out
//   d_req_*       D-cache request: same as the I port
//   mem_req_*     memory channel: valid/addr/wr/wr_data out, ready/data in
//   timeout_err   sticky memory timeout flag, cleared only by rst
// ----------------------------------------------------------------------------
//
// state | meaning
// ------+--------------------------------------------------------------------
// IDLE  | no transaction; arbitrate between valid requesters
// BUSY  | request presented to memory; waiting for mem_req_ready
// RESP  | owner's x_req_ready pulse is high for this single cycle
//
module mem_req_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 1023
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              i_req_valid,
    input  logic [ADDR_W-1:0] i_req_addr,
    input  logic              i_req_wr,
    input  logic [DATA_W-1:0] i_wr_data,
    output logic              i_req_ready,
    output logic [DATA_W-1:0] i_req_data,

    input  logic              d_req_valid,
    input  logic [ADDR_W-1:0] d_req_addr,
    input  logic              d_req_wr,
    input  logic [DATA_W-1:0] d_wr_data,
    output logic              d_req_ready,
    output logic [DATA_W-1:0] d_req_data,

    output logic              mem_req_valid,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic              mem_req_wr,
    output logic [DATA_W-1:0] mem_wr_data,
    input  logic              mem_req_ready,
    input  logic [DATA_W-1:0] mem_req_data,

    output logic              timeout_err
);

    // Counter is wide enough to hold TIMEOUT itself so it can saturate there.
    localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TO_MAX = CNT_W'(TIMEOUT);

    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state;
    logic             owner;
    logic             last_grant;
    logic [CNT_W-1:0] to_cnt;

    logic             req_any;
    logic             pick_d;

    // D wins when it is the only requester, or on a tie when I was served last.
    always_comb begin
        req_any = i_req_valid | d_req_valid;
        pick_d  = d_req_valid & (~i_req_valid | (last_grant == PORT_I));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            owner         <= PORT_I;
            last_grant    <= PORT_I;
            to_cnt        <= '0;
            timeout_err   <= 1'b0;
            mem_req_valid <= 1'b0;
            mem_req_addr  <= '0;
            mem_req_wr    <= 1'b0;
            mem_wr_data   <= '0;
            i_req_ready   <= 1'b0;
            i_req_data    <= '0;
            d_req_ready   <= 1'b0;
            d_req_data    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_any) begin
                        mem_req_valid <= 1'b1;
                        owner         <= pick_d;
                        last_grant    <= pick_d;
                        to_cnt        <= '0;
                        if (pick_d) begin
                            mem_req_addr <= d_req_addr;
                            mem_req_wr   <= d_req_wr;
                            mem_wr_data  <= d_wr_data;
                        end else begin
                            mem_req_addr <= i_req_addr;
                            mem_req_wr   <= i_req_wr;
                            mem_wr_data  <= i_wr_data;
                        end
                        state <= BUSY;
                    end
                end

                BUSY: begin
                    // Requester valid is deliberately not looked at here: once
                    // granted, the transaction always runs to completion.
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        if (owner == PORT_D) begin
                            d_req_data  <= mem_req_data;
                            d_req_ready <= 1'b1;
                        end else begin
                            i_req_data  <= mem_req_data;
                            i_req_ready <= 1'b1;
                        end
                        state <= RESP;
                    end else if (to_cnt != TO_MAX) begin
                        to_cnt <= to_cnt + CNT_W'(1);
                        if (to_cnt == TO_MAX - CNT_W'(1)) begin
                            timeout_err <= 1'b1;
                        end
                    end
                end

                RESP: begin
                    // No arbitration here, so a requester that drops valid in
                    // response to ready can never be granted a second time.
                    i_req_ready <= 1'b0;
                    d_req_ready <= 1'b0;
                    state       <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
